// File: rtl/laikas_stats_if.sv
// laikas_stats_if -- signal bundle between the test pattern generator /
// result reader (master) and the statistics block (slave).
//   RO, OW, Laikas : measurement strobe, invalid flag, interval value
//   CLEAR, RD      : statistics clear, FIFO pop
//   DOUT, DVALID, FULL, LEVEL : result FIFO head and status
//   CNT, MIN, MAX, SUM, REJ, DROP : running statistics and error counters
interface laikas_stats_if #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
);
    logic                       RO;
    logic                       OW;
    logic [31:0]                Laikas;
    logic                       CLEAR;
    logic                       RD;
    logic [31:0]                DOUT;
    logic                       DVALID;
    logic                       FULL;
    logic [$clog2(DEPTH):0]     LEVEL;
    logic [CNTW-1:0]            CNT;
    logic [31:0]                MIN;
    logic [31:0]                MAX;
    logic [CNTW+31:0]           SUM;
    logic [7:0]                 REJ;
    logic [7:0]                 DROP;

    modport master (
        output RO, OW, Laikas, CLEAR, RD,
        input  DOUT, DVALID, FULL, LEVEL, CNT, MIN, MAX, SUM, REJ, DROP
    );

    modport slave (
        input  RO, OW, Laikas, CLEAR, RD,
        output DOUT, DVALID, FULL, LEVEL, CNT, MIN, MAX, SUM, REJ, DROP
    );
endinterface

// File: rtl/laikas_stats.sv
// laikas_stats -- captures interval measurements on the rising edge of RO,
// keeps min/max/sum/count of valid samples and queues them in a
// first-word-fall-through result FIFO.
//   CLOCK_50 : single clock, rising edge
//   RESET    : asynchronous, active-high
//   bus      : laikas_stats_if slave (inputs RO/OW/Laikas/CLEAR/RD,
//              outputs FIFO head/status and statistics)
module laikas_stats #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    laikas_stats_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic             ro_q;
    logic             capture;
    logic             accept;
    logic             reject;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic [31:0]      mem [DEPTH];
    logic [31:0]      dout_q;
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW+31:0] sum_q;
    logic [31:0]      min_q;
    logic [31:0]      max_q;
    logic [7:0]       rej_q;
    logic [7:0]       drop_q;

    assign capture = bus.RO & ~ro_q;
    assign accept  = capture & ~bus.OW;
    assign reject  = capture & bus.OW;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = bus.RD & ~empty;
    // A pop frees the slot in the same edge, so a full FIFO still takes the push.
    assign push    = accept & (~full | pop);
    assign drop    = accept & full & ~pop;
    assign rd_next = rd_ptr + PTR_ONE;

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.Laikas;
        end
    end

    // The head register is reloaded whenever the oldest entry changes; when
    // the FIFO drains it simply keeps the last word.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            ro_q   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout_q <= '0;
        end else begin
            ro_q <= bus.RO;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_next;
                if (rd_next == wr_ptr) begin
                    if (push) begin
                        dout_q <= bus.Laikas;
                    end
                end else begin
                    dout_q <= mem[rd_next[AW-1:0]];
                end
            end else if (empty && push) begin
                dout_q <= bus.Laikas;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt_q  <= '0;
            sum_q  <= '0;
            min_q  <= 32'hFFFF_FFFF;
            max_q  <= '0;
            rej_q  <= '0;
            drop_q <= '0;
        end else if (bus.CLEAR) begin
            cnt_q  <= '0;
            sum_q  <= '0;
            min_q  <= 32'hFFFF_FFFF;
            max_q  <= '0;
            rej_q  <= '0;
            drop_q <= '0;
        end else begin
            // Statistics freeze once the count is saturated; SUM is wide
            // enough that it cannot wrap before that.
            if (accept && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
                sum_q <= sum_q + {{CNTW{1'b0}}, bus.Laikas};
                if (bus.Laikas < min_q) begin
                    min_q <= bus.Laikas;
                end
                if (bus.Laikas > max_q) begin
                    max_q <= bus.Laikas;
                end
            end
            if (reject && (rej_q != 8'hFF)) begin
                rej_q <= rej_q + 8'd1;
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign bus.DOUT   = dout_q;
    assign bus.DVALID = ~empty;
    assign bus.FULL   = full;
    assign bus.LEVEL  = wr_ptr - rd_ptr;
    assign bus.CNT    = cnt_q;
    assign bus.SUM    = sum_q;
    assign bus.MIN    = min_q;
    assign bus.MAX    = max_q;
    assign bus.REJ    = rej_q;
    assign bus.DROP   = drop_q;
endmodule

// File: doc/laikas_stats.md
LAIKAS_STATS -- requirements
Module: laikas_stats

Interface
REQ-001 Parameter DEPTH, default 8, sets the result FIFO depth in entries; it SHALL be a power of two, 2..64.
REQ-002 Parameter CNTW, default 16, sets the width of the accepted-sample counter CNT.
REQ-003 CLOCK_50  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  is the reset; it SHALL be asynchronous and active-high.
REQ-005 RO  in  1  is the result-ready level from the test pattern generator; its rising edge SHALL mark a new measurement.
REQ-006 OW  in  1  is the overflow/invalid flag from the generator, sampled with Laikas.
REQ-007 Laikas  in  32  is the measured interval in CLOCK_50 cycles.
REQ-008 CLEAR  in  1  is a synchronous clear of the statistics.
REQ-009 RD  in  1  is the FIFO pop strobe.
REQ-010 DOUT  out  32  is the FIFO head (first-word-fall-through).
REQ-011 DVALID  out  1  indicates the FIFO is non-empty.
REQ-012 FULL  out  1  indicates the FIFO holds DEPTH entries.
REQ-013 LEVEL  out  log2(DEPTH)+1  is the FIFO occupancy.
REQ-014 CNT  out  CNTW  is the accepted-sample count.
REQ-015 MIN / MAX  out  32 each  are the minimum / maximum of accepted samples.
REQ-016 SUM  out  CNTW+32  is the sum of accepted samples.
REQ-017 REJ / DROP  out  8 each  count OW-rejected samples and FIFO-overflow drops.

Function
REQ-018 The block SHALL register RO into ro_q; a capture event SHALL be RO=1 and ro_q=0 in the same cycle; RO held high SHALL produce one event only.
REQ-019 On a capture event, Laikas and OW SHALL be sampled in that cycle; all resulting output changes SHALL be visible in the following cycle (latency 1).
REQ-020 A capture with OW=1 SHALL be rejected: REJ increments (saturating at 255); FIFO and statistics are unchanged.
REQ-021 A capture with OW=0 SHALL be accepted: pushed to the FIFO if not full, else DROP increments (saturating at 255); statistics update whether or not the FIFO is full.
REQ-022 Statistics update: when CNT is below its all-ones value, CNT+1, SUM+sample, MIN=min(MIN,sample), MAX=max(MAX,sample); when CNT is all-ones, CNT, SUM, MIN and MAX SHALL freeze.
REQ-023 SUM SHALL never wrap, given its CNTW+32 width.
REQ-024 DOUT SHALL equal the oldest entry whenever DVALID=1; when empty, DOUT SHALL hold its last value.
REQ-025 RD with DVALID=1 SHALL pop one entry at the clock edge; RD with DVALID=0 SHALL be ignored.
REQ-026 Push and pop in the same cycle when full SHALL both occur; LEVEL stays DEPTH and nothing is dropped.
REQ-027 Push and RD in the same cycle when empty SHALL accept the push only; LEVEL becomes 1.
REQ-028 The FIFO SHALL use wrap-around read/write pointers with one extra bit; FULL and DVALID SHALL be derived from those pointers.
REQ-029 CLEAR=1 SHALL reset CNT, SUM, MIN, MAX, REJ and DROP to their reset values next cycle; it SHALL NOT affect FIFO contents.
REQ-030 If CLEAR coincides with a capture, CLEAR SHALL win for statistics and counters; the FIFO push SHALL still occur.

Reset
REQ-031 While RESET=1: FIFO empty, LEVEL=0, DVALID=0, FULL=0, DOUT=0, CNT=0, SUM=0, MIN=32'hFFFFFFFF, MAX=0, REJ=0, DROP=0, ro_q=0.
REQ-032 RESET asserted mid-operation SHALL discard FIFO contents and statistics immediately, independent of the clock.
REQ-033 If RO=1 when RESET deasserts, the first clock edge SHALL count as a capture event, because ro_q resets to 0.

Verification
REQ-034 RO pulses with Laikas=1000, 250, 4000 (OW=0) -> CNT=3, MIN=250, MAX=4000, SUM=5250; DOUT reads 1000, 250, 4000 in order.
REQ-035 RO pulse with OW=1, Laikas=77 -> REJ=1, CNT and LEVEL unchanged, MIN still 32'hFFFFFFFF.
REQ-036 Nine accepted captures with no RD (DEPTH=8) -> FULL=1, LEVEL=8, DROP=1, CNT=9; then RD asserted during a 10th capture -> LEVEL=8, DROP=1.
REQ-037 RO held high 20 cycles with Laikas=5 -> exactly one capture, CNT=1; RD while empty -> no change.
REQ-038 CLEAR in the same cycle as a capture of Laikas=9 -> CNT=0, MIN=32'hFFFFFFFF, LEVEL incremented, DOUT=9 if the FIFO was empty.
REQ-039 RESET pulse asynchronous to CLOCK_50, with LEVEL=3 and CNT=3 -> all outputs at reset values before the next edge; RO high at deassertion -> CNT=1 after the first edge.
